// File: rtl/max_pool.sv
// 2x2 stride-2 signed max pooling over a DRAM-resident feature map.
// Dimensions come from a 3-word record; reads issue in p0, accumulate/write happens in p1.
module max_pool #(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 18,
   parameter logic [ADDR_WIDTH-1:0] PARAM_BASE    = 18'd0,
   parameter logic [ADDR_WIDTH-1:0] FMAP_IN_BASE  = 18'd131072,
   parameter logic [ADDR_WIDTH-1:0] FMAP_OUT_BASE = 18'd196608
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  enable,
   input  logic                  dram_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  dram_en_rd,
   output logic                  dram_en_wr,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, LD_PARAM, EVAL, DONE} state_t;

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b);
      return (a >= b) ? a : b;
   endfunction

   state_t                        state, state_nxt;
   logic [1:0]                    pcnt;
   logic [4:0]                    wo, ho;
   logic [5:0]                    dim_d;
   logic [1:0]                    ph_p0;
   logic [3:0]                    ox_p0, oy_p0, d_p0;
   logic                          rd_done, vld_p0, last_rd_p0;
   logic                          ox_last, oy_last, d_last;
   logic [13:0]                   rd_ofs, wr_ofs;
   logic                          vld_p1, last_p1;
   logic [1:0]                    ph_p1;
   logic [ADDR_WIDTH-1:0]         oaddr_p1;
   logic signed [DATA_WIDTH-1:0]  din_s, acc_p1, wr_data;
   logic [DATA_WIDTH-1:0]         dout_q;
   logic                          unused_ok;

   // dram_valid exists only for interface uniformity; read latency is fixed
   assign unused_ok = dram_valid;

   assign vld_p0     = (state == EVAL) && !rd_done;
   assign ox_last    = ({1'b0, ox_p0} == wo - 5'd1);
   assign oy_last    = ({1'b0, oy_p0} == ho - 5'd1);
   assign d_last     = ({2'b0, d_p0} == dim_d - 6'd1);
   assign last_rd_p0 = (ph_p0 == 2'd3) && ox_last && oy_last && d_last;
   assign rd_ofs     = {d_p0, oy_p0, ph_p0[1], ox_p0, ph_p0[0]};
   assign wr_ofs     = {d_p0, 1'b0, oy_p0, 1'b0, ox_p0};

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (enable) state_nxt = LD_PARAM;
         LD_PARAM: if (pcnt == 2'd3)
                      state_nxt = (wo == 5'd0 || ho == 5'd0 || data_in[5:0] == 6'd0) ? DONE : EVAL;
         EVAL:     if (vld_p1 && last_p1) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      addr_in    = '0;
      dram_en_rd = 1'b0;
      done       = 1'b0;
      case (state)
         LD_PARAM: if (pcnt != 2'd3) begin
            dram_en_rd = 1'b1;
            addr_in    = PARAM_BASE + ADDR_WIDTH'(pcnt);
         end
         EVAL: if (vld_p0) begin
            dram_en_rd = 1'b1;
            addr_in    = FMAP_IN_BASE + ADDR_WIDTH'(rd_ofs);
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // p0: dimension capture and window/read-address sequencing
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         pcnt    <= 2'd0;
         wo      <= 5'd0;
         ho      <= 5'd0;
         dim_d   <= 6'd0;
         ph_p0   <= 2'd0;
         ox_p0   <= 4'd0;
         oy_p0   <= 4'd0;
         d_p0    <= 4'd0;
         rd_done <= 1'b0;
      end else begin
         pcnt <= (state == LD_PARAM) ? pcnt + 2'd1 : 2'd0;
         if (state == LD_PARAM) begin
            case (pcnt)
               2'd1:    wo    <= data_in[5:1];
               2'd2:    ho    <= data_in[5:1];
               2'd3:    dim_d <= data_in[5:0];
               default: ;
            endcase
         end
         if (state != EVAL) begin
            ph_p0   <= 2'd0;
            ox_p0   <= 4'd0;
            oy_p0   <= 4'd0;
            d_p0    <= 4'd0;
            rd_done <= 1'b0;
         end else if (vld_p0) begin
            ph_p0   <= ph_p0 + 2'd1;
            rd_done <= last_rd_p0;
            if (ph_p0 == 2'd3) begin
               if (ox_last) begin
                  ox_p0 <= 4'd0;
                  if (oy_last) begin
                     oy_p0 <= 4'd0;
                     d_p0  <= d_p0 + 4'd1;
                  end else begin
                     oy_p0 <= oy_p0 + 4'd1;
                  end
               end else begin
                  ox_p0 <= ox_p0 + 4'd1;
               end
            end
         end
      end
   end

   // p1: read data arrives; accumulate and emit the window maximum
   assign din_s      = $signed(data_in);
   assign wr_data    = smax(acc_p1, din_s);
   assign dram_en_wr = vld_p1 && (ph_p1 == 2'd3);
   assign data_out   = dram_en_wr ? $unsigned(wr_data) : dout_q;
   assign addr_out   = oaddr_p1;

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         vld_p1   <= 1'b0;
         last_p1  <= 1'b0;
         ph_p1    <= 2'd0;
         oaddr_p1 <= '0;
         acc_p1   <= '0;
         dout_q   <= '0;
      end else begin
         vld_p1  <= vld_p0;
         last_p1 <= vld_p0 && last_rd_p0;
         ph_p1   <= ph_p0;
         if (vld_p0) oaddr_p1 <= FMAP_OUT_BASE + ADDR_WIDTH'(wr_ofs);
         if (vld_p1) begin
            case (ph_p1)
               2'd0:    acc_p1 <= din_s;
               2'd3:    dout_q <= $unsigned(wr_data);
               default: acc_p1 <= smax(acc_p1, din_s);
            endcase
         end
      end
   end

endmodule
